// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller.
//   - FSM state encoding
//   - default parameter values (line count, handler table base, entry stride)
//   - width of the granted-line index
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  localparam int          DEF_NUM_IRQ    = 8;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam int          DEF_VEC_STRIDE = 4;

  // Index width; a single line still needs a 1-bit id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Per-line 2-flop synchronizer plus rising-edge pulse.
// Ports:
//   clk  - clock
//   rst  - async active-low reset, clears all three flops
//   din  - raw asynchronous line
//   rise - one-cycle pulse when the synchronized line goes 0->1
// Because the delay flop resets to 0, a line already high at reset
// release produces exactly one pulse; a held-high line produces no more.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, fixed-priority (lowest index wins), non-nesting
// interrupt controller.
// Ports:
//   clk, rst         - clock, async active-low reset
//   irq_in           - raw interrupt lines, rising edge significant
//   mask_wr/mask_data- mask register load (1 = enabled), resets to all-ones
//   ack              - core took the request; clears pending[irq_id]
//   eoi              - core finished the handler
//   INT              - request to core (high in REQ)
//   irq_id, vector   - granted line and its handler address, latched on grant
//   pending          - pending register, not masked
//   busy             - handler in service
module interrupt_controller
  import intc_pkg::*;
#(
  parameter  int          NUM_IRQ    = DEF_NUM_IRQ,
  parameter  logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter  int          VEC_STRIDE = DEF_VEC_STRIDE,
  localparam int          ID_W       = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               ack,
  input  logic               eoi,
  output logic               INT,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending_q, mask_q, eligible, clr;
  logic [ID_W-1:0]    grant_id;
  logic [31:0]        grant_vec;
  logic               latch, take;
  intc_state_e        state_q, state_d;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    sync_edge_detect u_sed (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign eligible = pending_q & mask_q;

  // Lowest-index eligible line: scan high to low so the last hit wins.
  always_comb begin
    grant_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (eligible[i]) grant_id = ID_W'(i);
  end

  assign grant_vec = VEC_BASE + 32'(grant_id) * 32'(VEC_STRIDE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: if (|eligible) begin
        state_d = ST_REQ;
        latch   = 1'b1;
      end
      ST_REQ: if (ack) begin
        state_d = ST_SERVICE;
        take    = 1'b1;
      end
      ST_SERVICE: if (eoi) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr = take ? (NUM_IRQ'(1) << irq_id) : '0;

  // Set after clear: an edge arriving with ack re-arms the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      mask_q    <= '1;
      irq_id    <= '0;
      vector    <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
      if (mask_wr) mask_q <= mask_data;
      if (latch) begin
        irq_id <= grant_id;
        vector <= grant_vec;
      end
    end
  end

  assign INT     = (state_q == ST_REQ);
  assign busy    = (state_q == ST_SERVICE);
  assign pending = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in, mask_data;
  logic       mask_wr, ack, eoi;
  logic       INT, busy;
  logic [2:0] irq_id;
  logic [31:0] vector;
  logic [7:0] pending;

  int checks = 0;
  int failures = 0;

  interrupt_controller dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
    .mask_data(mask_data), .ack(ack), .eoi(eoi), .INT(INT),
    .irq_id(irq_id), .vector(vector), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled lines, pending set, mask, and
  // the request phase (0 waiting, 1 requesting, 2 in service).
  logic [7:0]  h1, h2, h3;   // samples taken 1, 2, 3 edges ago
  logic [7:0]  m_pend, m_mask;
  int          m_ph, m_id;
  logic [31:0] m_vec;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic mreset();
    h1 = 0; h2 = 0; h3 = 0;
    m_pend = 0; m_mask = 8'hFF; m_ph = 0; m_id = 0; m_vec = 0;
  endtask

  // One clock edge; the model advances using the inputs held across it.
  task automatic tick();
    logic [7:0] p;
    int ph, id;
    logic [31:0] v;
    @(posedge clk);
    p = m_pend; ph = m_ph; id = m_id; v = m_vec;
    if (m_ph == 1 && ack) p[m_id] = 1'b0;
    p = p | (h2 & ~h3);              // line sampled high 2 edges ago after a low
    if (m_ph == 0 && (m_pend & m_mask) != 0) begin
      ph = 1; id = lowest(m_pend & m_mask); v = 32'h100 + 32'(id) * 4;
    end else if (m_ph == 1 && ack) ph = 2;
    else if (m_ph == 2 && eoi) ph = 0;
    if (mask_wr) m_mask = mask_data;
    h3 = h2; h2 = h1; h1 = irq_in;
    m_pend = p; m_ph = ph; m_id = id; m_vec = v;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    mreset();
    #1;
  endtask

  task automatic test_reset();
    irq_in = 8'h80; mask_wr = 0; mask_data = 0; ack = 0; eoi = 0;
    rst = 1'b1;
    #3 rst = 1'b0; mreset();
    #1;
    checks++;
    if ({INT, busy, irq_id, vector, pending} !== 44'd0) begin
      failures++;
      $display("FAIL reset_outputs got INT=%b busy=%b id=%0d vec=%h pend=%h want all zero",
               INT, busy, irq_id, vector, pending);
    end
    checks++;
    if (dut.mask_q !== 8'hFF) begin
      failures++; $display("FAIL reset_mask got %h want ff", dut.mask_q);
    end
    ticks(2);
    rst = 1'b1;                       // line 7 high at release: one edge
    ticks(4);
    checks++;
    if (INT !== 1'b1 || irq_id !== 3'd7 || vector !== 32'h11C) begin
      failures++;
      $display("FAIL reset_release_edge got INT=%b id=%0d vec=%h want 1 7 0000011c", INT, irq_id, vector);
    end
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    ticks(3);                         // held high: no second event
    checks++;
    if (INT !== 1'b0 || pending !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL held_high_once got INT=%b pend=%h busy=%b want 0 00 0", INT, pending, busy);
    end
    irq_in = 0; ticks(3);
  endtask

  task automatic test_single();
    irq_in[3] = 1'b1;
    ticks(3);
    checks++;
    if (pending !== 8'h08 || INT !== 1'b0) begin
      failures++; $display("FAIL single_pend_k2 got pend=%h INT=%b want 08 0", pending, INT);
    end
    tick();
    checks++;
    if (INT !== 1'b1 || irq_id !== 3'd3 || vector !== 32'h10C) begin
      failures++; $display("FAIL single_grant got INT=%b id=%0d vec=%h want 1 3 0000010c", INT, irq_id, vector);
    end
    ack = 1; tick(); ack = 0;
    checks++;
    if (INT !== 1'b0 || busy !== 1'b1 || pending[3] !== 1'b0) begin
      failures++; $display("FAIL single_ack got INT=%b busy=%b pend3=%b want 0 1 0", INT, busy, pending[3]);
    end
    ack = 1; tick(); ack = 0;        // ack in SERVICE is ignored
    eoi = 1; tick(); eoi = 0;
    checks++;
    if (busy !== 1'b0 || INT !== 1'b0) begin
      failures++; $display("FAIL single_eoi got busy=%b INT=%b want 0 0", busy, INT);
    end
    irq_in[3] = 1'b0; ticks(3);
  endtask

  task automatic test_priority();
    irq_in[5] = 1'b1; irq_in[2] = 1'b1;
    ticks(4);
    checks++;
    if (INT !== 1'b1 || irq_id !== 3'd2 || vector !== 32'h108) begin
      failures++; $display("FAIL prio_first got INT=%b id=%0d vec=%h want 1 2 00000108", INT, irq_id, vector);
    end
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    tick();
    checks++;
    if (INT !== 1'b1 || irq_id !== 3'd5 || vector !== 32'h114) begin
      failures++; $display("FAIL prio_second got INT=%b id=%0d vec=%h want 1 5 00000114", INT, irq_id, vector);
    end
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    irq_in = 0; ticks(3);
  endtask

  task automatic test_mask();
    mask_wr = 1; mask_data = 8'hFB; tick(); mask_wr = 0;
    irq_in[2] = 1'b1;
    ticks(6);
    checks++;
    if (pending[2] !== 1'b1 || INT !== 1'b0) begin
      failures++; $display("FAIL mask_hold got pend2=%b INT=%b want 1 0", pending[2], INT);
    end
    mask_wr = 1; mask_data = 8'hFF; tick(); mask_wr = 0;
    tick();
    checks++;
    if (INT !== 1'b1 || irq_id !== 3'd2) begin
      failures++; $display("FAIL mask_release got INT=%b id=%0d want 1 2", INT, irq_id);
    end
    mask_wr = 1; mask_data = 8'h00; tick(); mask_wr = 0;   // no withdrawal in REQ
    checks++;
    if (INT !== 1'b1 || irq_id !== 3'd2) begin
      failures++; $display("FAIL mask_in_req got INT=%b id=%0d want 1 2", INT, irq_id);
    end
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    mask_wr = 1; mask_data = 8'hFF; tick(); mask_wr = 0;
    irq_in = 0; ticks(3);
  endtask

  task automatic test_ack_reedge();
    irq_in[1] = 1'b1;                 // sampled high at edge k
    ticks(4);                         // INT after k+3
    irq_in[1] = 1'b0; tick();         // k+4 low
    irq_in[1] = 1'b1; tick();         // k+5 high, pending at k+7
    tick();
    ack = 1; tick(); ack = 0;         // ack on k+7
    checks++;
    if (busy !== 1'b1 || pending[1] !== 1'b1) begin
      failures++; $display("FAIL ack_reedge got busy=%b pend1=%b want 1 1", busy, pending[1]);
    end
    eoi = 1; tick(); eoi = 0;
    tick();
    checks++;
    if (INT !== 1'b1 || irq_id !== 3'd1 || vector !== 32'h104) begin
      failures++; $display("FAIL ack_reedge_second got INT=%b id=%0d vec=%h want 1 1 00000104", INT, irq_id, vector);
    end
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    irq_in = 0; ticks(3);
  endtask

  task automatic test_reset_service();
    mask_wr = 1; mask_data = 8'h5F; tick(); mask_wr = 0;
    irq_in[4] = 1'b1; irq_in[6] = 1'b1;
    ticks(4);
    ack = 1; tick(); ack = 0;
    checks++;
    if (busy !== 1'b1 || irq_id !== 3'd4) begin
      failures++; $display("FAIL rst_setup got busy=%b id=%0d want 1 4", busy, irq_id);
    end
    irq_in = 0;
    do_reset();
    checks++;
    if (INT !== 1'b0 || busy !== 1'b0 || pending !== 8'h00 || dut.mask_q !== 8'hFF) begin
      failures++;
      $display("FAIL rst_in_service got INT=%b busy=%b pend=%h mask=%h want 0 0 00 ff",
               INT, busy, pending, dut.mask_q);
    end
    tick();
    rst = 1'b1;
    eoi = 1; tick(); eoi = 0;
    ticks(4);
    checks++;
    if (INT !== 1'b0 || busy !== 1'b0 || pending !== 8'h00) begin
      failures++; $display("FAIL rst_eoi_ignored got INT=%b busy=%b pend=%h want 0 0 00", INT, busy, pending);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 9) == 0) irq_in[i] = ~irq_in[i];
      mask_wr   = ($urandom_range(0, 15) == 0);
      mask_data = 8'($urandom);
      ack       = ($urandom_range(0, 3) == 0);
      eoi       = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({INT, busy, irq_id, vector, pending} !==
          {m_ph == 1, m_ph == 2, 3'(m_id), m_vec, m_pend}) begin
        failures++;
        $display("FAIL random_cycle%0d got INT=%b busy=%b id=%0d vec=%h pend=%h want %b %b %0d %h %h",
                 c, INT, busy, irq_id, vector, pending, m_ph == 1, m_ph == 2, m_id, m_vec, m_pend);
      end
    end
    ack = 0; eoi = 0; mask_wr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_ack_reedge();
    test_reset_service();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
